sm_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 4-bit sign-magnitude adder between up to four requesters. It sits between the requesting datapath blocks and the adder core. It captures one operand pair per grant, registers the result, and returns it with a one-cycle valid/grant pulse tagged with the requester index. Negative zero is normalised, and same-sign overflow is flagged.

---
 rtl/sm_add_arbiter_pkg.sv | 30 +++
 rtl/sm_add_arbiter_core.sv | 55 +++++
 rtl/sm_add_arbiter.sv | 155 +++++++++++++++
 tb/tb_sm_add_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sm_add_arbiter_pkg.sv
// Shared definitions for the sign-magnitude adder arbiter: field widths,
// FSM state encoding and helpers to split/pack sign-magnitude words.
package sm_arb_pkg;

    localparam int MAG_W    = 3;
    localparam int SM_W     = 4;
    localparam int SIGN_BIT = SM_W - 1;

    // Largest representable magnitude, used as the saturation value
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic sign_of(input logic [SM_W-1:0] v);
        return v[SIGN_BIT];
    endfunction

    function automatic logic [MAG_W-1:0] mag_of(input logic [SM_W-1:0] v);
        return v[MAG_W-1:0];
    endfunction

    function automatic logic [SM_W-1:0] pack_sm(input logic s, input logic [MAG_W-1:0] m);
        return {s, m};
    endfunction

endpackage

// File: rtl/sm_add_arbiter_core.sv
// Combinational 4-bit sign-magnitude adder with negative-zero normalisation
// and same-sign overflow detection.
// Build option: define SM_ADD_ARB_SAT_EN to saturate the magnitude on
// overflow; otherwise the magnitude wraps.
module sm_add_core
    import sm_arb_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] res,
    output logic            ovf
);

    logic             sa;
    logic             sb;
    logic [MAG_W-1:0] ma;
    logic [MAG_W-1:0] mb;
    logic [MAG_W:0]   sum_next;
    logic [MAG_W-1:0] mag_next;
    logic             sign_next;

    assign sa = sign_of(a);
    assign sb = sign_of(b);
    assign ma = mag_of(a);
    assign mb = mag_of(b);

    // Add or subtract magnitudes depending on the signs, then force +0
    always_comb begin
        sum_next  = {1'b0, ma} + {1'b0, mb};
        mag_next  = '0;
        sign_next = 1'b0;
        ovf       = 1'b0;
        if (sa == sb) begin
            sign_next = sa;
            ovf       = sum_next[MAG_W];
`ifdef SM_ADD_ARB_SAT_EN
            mag_next  = sum_next[MAG_W] ? MAG_MAX : sum_next[MAG_W-1:0];
`else
            mag_next  = sum_next[MAG_W-1:0];
`endif
        end else if (ma >= mb) begin
            sign_next = sa;
            mag_next  = ma - mb;
        end else begin
            sign_next = sb;
            mag_next  = mb - ma;
        end
        // A zero magnitude is always reported as +0
        if (mag_next == '0) begin
            sign_next = 1'b0;
        end
        res = pack_sm(sign_next, mag_next);
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder among up to four
// requesters. One operation per IDLE->EXEC->RESP slot; results and the
// one-cycle valid/gnt pulse are fully registered.
// Build option: SM_ADD_ARB_SAT_EN selects saturating overflow in the adder.
module sm_add_arbiter
    import sm_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    a_in,
    input  logic [4*NREQ-1:0]    b_in,
    output logic [NREQ-1:0]      gnt,
    output logic [SM_W-1:0]      res,
    output logic                 ovf,
    output logic                 valid,
    output logic [1:0]           id,
    output logic                 busy
);

    localparam int MAX_REQ = 4;

    state_t            state_reg;
    logic [1:0]        ptr_reg;
    logic [1:0]        win_reg;
    logic [SM_W-1:0]   a_lat_reg;
    logic [SM_W-1:0]   b_lat_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [SM_W-1:0]   res_reg;
    logic              ovf_reg;
    logic              valid_reg;
    logic [1:0]        id_reg;
    logic              busy_reg;

    // Requests and operands padded to four slots so they can be indexed by
    // a 2-bit pointer regardless of NREQ
    logic [MAX_REQ-1:0] req_pad;
    logic [SM_W-1:0]    a_pad [MAX_REQ];
    logic [SM_W-1:0]    b_pad [MAX_REQ];
    logic [NREQ-1:0]    gnt_dec;

    logic              found_next;
    logic [1:0]        win_next;
    logic [1:0]        ptr_next;

    logic [SM_W-1:0]   core_res;
    logic              core_ovf;

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_slot
            if (gi < NREQ) begin : g_live
                assign req_pad[gi] = req[gi];
                assign a_pad[gi]   = a_in[SM_W*gi +: SM_W];
                assign b_pad[gi]   = b_in[SM_W*gi +: SM_W];
            end else begin : g_unused
                assign req_pad[gi] = 1'b0;
                assign a_pad[gi]   = '0;
                assign b_pad[gi]   = '0;
            end
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt_dec[gi] = (win_reg == 2'(gi));
        end
    endgenerate

    // Round-robin search starting at ptr; first requester with req high wins
    always_comb begin
        int slot;
        found_next = 1'b0;
        win_next   = ptr_reg;
        slot       = 0;
        for (int k = 0; k < NREQ; k++) begin
            slot = int'(ptr_reg) + k;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            if (!found_next && req_pad[slot[1:0]]) begin
                found_next = 1'b1;
                win_next   = slot[1:0];
            end
        end
        if (win_next == 2'(NREQ - 1)) begin
            ptr_next = 2'd0;
        end else begin
            ptr_next = win_next + 2'd1;
        end
    end

    sm_add_core u_core (
        .a   (a_lat_reg),
        .b   (b_lat_reg),
        .res (core_res),
        .ovf (core_ovf)
    );

    // Sequencer FSM with operand latches and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd0;
            win_reg   <= 2'd0;
            a_lat_reg <= '0;
            b_lat_reg <= '0;
            gnt_reg   <= '0;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            id_reg    <= 2'd0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found_next) begin
                        state_reg <= EXEC;
                        win_reg   <= win_next;
                        a_lat_reg <= a_pad[win_next];
                        b_lat_reg <= b_pad[win_next];
                        ptr_reg   <= ptr_next;
                        busy_reg  <= 1'b1;
                    end
                end
                EXEC: begin
                    state_reg <= RESP;
                    res_reg   <= core_res;
                    ovf_reg   <= core_ovf;
                    id_reg    <= win_reg;
                    valid_reg <= 1'b1;
                    gnt_reg   <= gnt_dec;
                end
                RESP: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign res   = res_reg;
    assign ovf   = ovf_reg;
    assign valid = valid_reg;
    assign id    = id_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_sm_add_arbiter.sv
// Directed, table-driven bench for sm_add_arbiter with NREQ=2, plus
// hand-written fairness and reset-during-EXEC sequences.
module tb_sm_add_arbiter;

    localparam int NREQ = 2;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] a_in;
    logic [4*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [3:0]        res;
    logic              ovf;
    logic              valid;
    logic [1:0]        id;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    sm_add_arbiter #(.NREQ(NREQ)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .res     (res),
        .ovf     (ovf),
        .valid   (valid),
        .id      (id),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request/response transaction on requester idx
    task automatic run_op(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] er, input logic eo);
        logic [NREQ-1:0] eg;
        eg = '0;
        eg[idx] = 1'b1;
        @(negedge clk);
        req = '0;
        req[idx] = 1'b1;
        a_in[4*idx +: 4] = a;
        b_in[4*idx +: 4] = b;
        @(posedge clk); #1;
        chk("exec_busy", 8'(busy), 8'd1);
        chk("exec_valid", 8'(valid), 8'd0);
        chk("exec_gnt", 8'(gnt), 8'd0);
        @(posedge clk); #1;
        chk("resp_valid", 8'(valid), 8'd1);
        chk("resp_gnt", 8'(gnt), 8'(eg));
        chk("resp_id", 8'(id), 8'(idx));
        chk("resp_res", 8'(res), 8'(er));
        chk("resp_ovf", 8'(ovf), 8'(eo));
        $display("op req=%0d a=%b b=%b res=%b ovf=%0d id=%0d", idx, a, b, res, ovf, id);
        @(posedge clk); #1;
        req = '0;
        chk("idle_valid", 8'(valid), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_res_hold", 8'(res), 8'(er));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int gcyc[4];
        int gid[4];
        int ng;

`ifdef SM_ADD_ARB_SAT_EN
        vecs[5] = '{idx: 1, a: 4'b0110, b: 4'b0101, res: 4'b0111, ovf: 1'b1};
        vecs[6] = '{idx: 0, a: 4'b1101, b: 4'b1100, res: 4'b1111, ovf: 1'b1};
        vecs[7] = '{idx: 1, a: 4'b0100, b: 4'b0100, res: 4'b0111, ovf: 1'b1};
`else
        vecs[5] = '{idx: 1, a: 4'b0110, b: 4'b0101, res: 4'b0011, ovf: 1'b1};
        vecs[6] = '{idx: 0, a: 4'b1101, b: 4'b1100, res: 4'b1001, ovf: 1'b1};
        vecs[7] = '{idx: 1, a: 4'b0100, b: 4'b0100, res: 4'b0000, ovf: 1'b1};
`endif
        vecs[0] = '{idx: 0, a: 4'b0011, b: 4'b0010, res: 4'b0101, ovf: 1'b0};
        vecs[1] = '{idx: 1, a: 4'b0011, b: 4'b1101, res: 4'b1010, ovf: 1'b0};
        vecs[2] = '{idx: 0, a: 4'b0011, b: 4'b1011, res: 4'b0000, ovf: 1'b0};
        vecs[3] = '{idx: 1, a: 4'b1000, b: 4'b1000, res: 4'b0000, ovf: 1'b0};
        vecs[4] = '{idx: 0, a: 4'b1010, b: 4'b0111, res: 4'b0101, ovf: 1'b0};
        vecs[8] = '{idx: 0, a: 4'b1111, b: 4'b0001, res: 4'b1110, ovf: 1'b0};
        vecs[9] = '{idx: 1, a: 4'b1011, b: 4'b1100, res: 4'b1111, ovf: 1'b0};

        reset_n = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        #1;
        chk("rst_gnt", 8'(gnt), 8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_res", 8'(res), 8'd0);
        chk("rst_id", 8'(id), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf);
        end

        // Fairness: both requesters held high from reset release
        @(negedge clk);
        reset_n = 1'b0;
        req  = 2'b11;
        a_in = {4'b0001, 4'b0010};
        b_in = {4'b0001, 4'b0001};
        @(negedge clk);
        reset_n = 1'b1;
        ng = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            chk("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);
            if (valid && ng < 4) begin
                gcyc[ng] = c;
                gid[ng]  = int'(id);
                $display("fair grant id=%0d cycle=%0d res=%b", id, c, res);
                ng++;
            end
        end
        req = '0;
        chk("fair_count", 8'(ng), 8'd4);
        if (ng == 4) begin
            chk("fair_first_cycle", 8'(gcyc[0]), 8'd1);
            for (int k = 0; k < 4; k++) begin
                chk("fair_order", 8'(gid[k]), 8'(k % 2));
                if (k > 0) chk("fair_spacing", 8'(gcyc[k] - gcyc[k-1]), 8'd3);
            end
        end
        @(posedge clk); @(posedge clk);

        // Reset during EXEC: ptr returns to 0 so req0 wins afterwards
        do_reset();
        run_op(0, 4'b0011, 4'b0010, 4'b0101, 1'b0);
        @(negedge clk);
        req  = 2'b11;
        a_in = {4'b0111, 4'b0001};
        b_in = {4'b0111, 4'b0001};
        @(posedge clk); #1;
        chk("pre_rst_busy", 8'(busy), 8'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(valid), 8'd0);
        chk("mid_rst_gnt", 8'(gnt), 8'd0);
        chk("mid_rst_res", 8'(res), 8'd0);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_ovf", 8'(ovf), 8'd0);
        chk("mid_rst_id", 8'(id), 8'd0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_hold_valid", 8'(valid), 8'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 8'(busy), 8'd1);
        chk("post_rst_valid", 8'(valid), 8'd0);
        @(posedge clk); #1;
        chk("post_rst_valid2", 8'(valid), 8'd1);
        chk("post_rst_gnt", 8'(gnt), 8'b01);
        chk("post_rst_id", 8'(id), 8'd0);
        chk("post_rst_res", 8'(res), 8'b0010);
        $display("post-reset op id=%0d res=%b ovf=%0d", id, res, ovf);
        req = '0;
        @(posedge clk); @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
